// File: rtl/queue_fifo.sv
// Parametrised valid/ready FIFO with occupancy count, almost-full/empty flags,
// synchronous flush and registered, bypass or pipe flow modes.
module queue_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 4,
  parameter int AFULL_LEVEL  = DEPTH - 1,
  parameter int AEMPTY_LEVEL = 1,
  parameter int MODE         = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       enq_valid,
  input  logic [DATA_WIDTH-1:0]      enq_data,
  output logic                       enq_ready,
  input  logic                       deq_ready,
  output logic                       deq_valid,
  output logic [DATA_WIDTH-1:0]      deq_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full,
  output logic                       almost_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_CNT  = CNT_W'(AFULL_LEVEL);
  localparam logic [CNT_W-1:0] AEMPTY_CNT = CNT_W'(AEMPTY_LEVEL);

  generate
    if (DEPTH < 2) begin : g_bad_depth
      $error("queue_fifo: DEPTH must be at least 2");
    end
    if (MODE > 2) begin : g_bad_mode
      $error("queue_fifo: MODE must be 0, 1 or 2");
    end
    if (AFULL_LEVEL > DEPTH) begin : g_bad_afull
      $error("queue_fifo: AFULL_LEVEL must not exceed DEPTH");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;

  logic is_empty;
  logic is_full;
  logic bypass_active;
  logic enq_fire;
  logic deq_fire;
  logic pass_through;
  logic wr_en;
  logic rd_en;

  assign is_empty      = (count == '0);
  assign is_full       = (count == FULL_CNT);
  assign bypass_active = (MODE == 1) && is_empty;

  // In pipe mode a full queue still accepts when the head leaves this cycle.
  assign enq_ready = (MODE == 2) ? (!is_full || deq_ready) : !is_full;
  assign deq_valid = bypass_active ? enq_valid : !is_empty;
  assign deq_data  = bypass_active ? enq_data : mem[head];

  assign enq_fire     = enq_valid && enq_ready;
  assign deq_fire     = deq_valid && deq_ready;
  assign pass_through = bypass_active && enq_fire && deq_fire;
  assign wr_en        = enq_fire && !pass_through && !flush;
  assign rd_en        = deq_fire && !pass_through && !flush;

  assign almost_full  = (count >= AFULL_CNT);
  assign almost_empty = (count <= AEMPTY_CNT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[tail] <= enq_data;
      end
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (wr_en) begin
          tail <= (tail == LAST_PTR) ? '0 : tail + PTR_W'(1);
        end
        if (rd_en) begin
          head <= (head == LAST_PTR) ? '0 : head + PTR_W'(1);
        end
        if (wr_en && !rd_en) begin
          count <= count + CNT_W'(1);
        end else if (rd_en && !wr_en) begin
          count <= count - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_queue_fifo.sv
// Bench for queue_fifo: four instances (registered depth 4 and 3, bypass, pipe)
// checked every cycle against a list-based model plus directed literal checks.
module tb_queue_fifo;

  logic       clk;
  logic       reset;
  logic       ev [4];
  logic       rd [4];
  logic       fl [4];
  logic [7:0] ed [4];
  logic       er [4];
  logic       dv [4];
  logic       afl [4];
  logic       aem [4];
  logic [7:0] dd [4];
  logic [2:0] cnt0;
  logic [1:0] cnt1;
  logic [2:0] cnt2;
  logic [2:0] cnt3;

  int assertCount;
  int failCount;

  localparam int DEP   [4] = '{4, 3, 4, 4};
  localparam int MODEV [4] = '{0, 0, 1, 2};
  localparam int AFL   [4] = '{3, 2, 3, 3};

  logic [7:0] ms [4][8];
  int         mn [4];
  logic [7:0] outLog [$];

  queue_fifo #(.DATA_WIDTH(8), .DEPTH(4), .MODE(0)) u0 (
    .clk(clk), .reset(reset), .flush(fl[0]), .enq_valid(ev[0]), .enq_data(ed[0]),
    .enq_ready(er[0]), .deq_ready(rd[0]), .deq_valid(dv[0]), .deq_data(dd[0]),
    .count(cnt0), .almost_full(afl[0]), .almost_empty(aem[0]));

  queue_fifo #(.DATA_WIDTH(8), .DEPTH(3), .MODE(0)) u1 (
    .clk(clk), .reset(reset), .flush(fl[1]), .enq_valid(ev[1]), .enq_data(ed[1]),
    .enq_ready(er[1]), .deq_ready(rd[1]), .deq_valid(dv[1]), .deq_data(dd[1]),
    .count(cnt1), .almost_full(afl[1]), .almost_empty(aem[1]));

  queue_fifo #(.DATA_WIDTH(8), .DEPTH(4), .MODE(1)) u2 (
    .clk(clk), .reset(reset), .flush(fl[2]), .enq_valid(ev[2]), .enq_data(ed[2]),
    .enq_ready(er[2]), .deq_ready(rd[2]), .deq_valid(dv[2]), .deq_data(dd[2]),
    .count(cnt2), .almost_full(afl[2]), .almost_empty(aem[2]));

  queue_fifo #(.DATA_WIDTH(8), .DEPTH(4), .MODE(2)) u3 (
    .clk(clk), .reset(reset), .flush(fl[3]), .enq_valid(ev[3]), .enq_data(ed[3]),
    .enq_ready(er[3]), .deq_ready(rd[3]), .deq_valid(dv[3]), .deq_data(dd[3]),
    .count(cnt3), .almost_full(afl[3]), .almost_empty(aem[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int dutCount(int i);
    case (i)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      2:       return int'(cnt2);
      default: return int'(cnt3);
    endcase
  endfunction

  function automatic logic mReady(int i);
    return (mn[i] < DEP[i]) || (MODEV[i] == 2 && rd[i]);
  endfunction

  function automatic logic mValid(int i);
    return (mn[i] > 0) || (MODEV[i] == 1 && ev[i]);
  endfunction

  function automatic logic [7:0] mData(int i);
    return (mn[i] > 0) ? ms[i][0] : ed[i];
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int i, input logic v, input logic [7:0] d,
                               input logic r, input logic f);
    ev[i] = v;
    ed[i] = d;
    rd[i] = r;
    fl[i] = f;
    @(posedge clk);
    #1;
  endtask

  task automatic setIdle(input int i);
    ev[i] = 1'b0;
    rd[i] = 1'b0;
    fl[i] = 1'b0;
    #1;
  endtask

  // Model: the queue is an ordered list; a fire pops the front or appends at the back.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) mn[i] = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        automatic logic ef = ev[i] && mReady(i);
        automatic logic df = mValid(i) && rd[i];
        if (fl[i]) begin
          mn[i] = 0;
        end else if (!(mn[i] == 0 && ef && df)) begin
          if (df) begin
            for (int k = 0; k < 7; k++) ms[i][k] = ms[i][k+1];
            mn[i] = mn[i] - 1;
          end
          if (ef) begin
            ms[i][mn[i]] = ed[i];
            mn[i] = mn[i] + 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("u%0d enq_ready", i), int'(er[i]), int'(mReady(i)));
      checkOutput($sformatf("u%0d deq_valid", i), int'(dv[i]), int'(mValid(i)));
      checkOutput($sformatf("u%0d count", i), dutCount(i), mn[i]);
      checkOutput($sformatf("u%0d almost_full", i), int'(afl[i]), int'(mn[i] >= AFL[i]));
      checkOutput($sformatf("u%0d almost_empty", i), int'(aem[i]), int'(mn[i] <= 1));
      if (mValid(i)) begin
        checkOutput($sformatf("u%0d deq_data", i), int'(dd[i]), int'(mData(i)));
      end
    end
    if (dv[1] && rd[1]) outLog.push_back(dd[1]);
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] fill [4];
    logic [7:0] pipeExp [4];
    assertCount = 0;
    failCount   = 0;
    fill    = '{8'h11, 8'h22, 8'h33, 8'h44};
    pipeExp = '{8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 4; i++) begin
      ev[i] = 1'b0; rd[i] = 1'b0; fl[i] = 1'b0; ed[i] = 8'h00;
    end
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;

    $display("[TB] reset state");
    checkOutput("reset count", dutCount(0), 0);
    checkOutput("reset enq_ready", int'(er[0]), 1);
    checkOutput("reset deq_valid", int'(dv[0]), 0);
    checkOutput("reset deq_data", int'(dd[0]), 0);
    checkOutput("reset almost_full", int'(afl[0]), 0);
    checkOutput("reset almost_empty", int'(aem[0]), 1);

    $display("[TB] fill depth-4 registered queue");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 1'b1, fill[k], 1'b0, 1'b0);
      setIdle(0);
      checkOutput("fill count", dutCount(0), k + 1);
      checkOutput("fill almost_full", int'(afl[0]), int'(k + 1 >= 3));
    end
    checkOutput("full enq_ready", int'(er[0]), 0);
    checkOutput("full head data", int'(dd[0]), 8'h11);

    $display("[TB] flush with pending enqueue");
    applyStimulus(0, 1'b0, 8'h00, 1'b1, 1'b0);
    setIdle(0);
    checkOutput("pre-flush count", dutCount(0), 3);
    applyStimulus(0, 1'b1, 8'h99, 1'b0, 1'b1);
    setIdle(0);
    checkOutput("flush count", dutCount(0), 0);
    checkOutput("flush deq_valid", int'(dv[0]), 0);
    checkOutput("flush enq_ready", int'(er[0]), 1);
    applyStimulus(0, 1'b1, 8'h77, 1'b0, 1'b0);
    setIdle(0);
    checkOutput("post-flush head", int'(dd[0]), 8'h77);

    $display("[TB] depth-3 wrap");
    for (int k = 1; k <= 3; k++) applyStimulus(1, 1'b1, 8'(k), 1'b0, 1'b0);
    applyStimulus(1, 1'b0, 8'h00, 1'b1, 1'b0);
    for (int k = 4; k <= 10; k++) applyStimulus(1, 1'b1, 8'(k), 1'b1, 1'b0);
    applyStimulus(1, 1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1, 1'b0, 8'h00, 1'b1, 1'b0);
    setIdle(1);
    checkOutput("wrap log size", outLog.size(), 10);
    for (int k = 0; k < outLog.size(); k++) begin
      checkOutput($sformatf("wrap order %0d", k), int'(outLog[k]), k + 1);
    end

    $display("[TB] bypass mode");
    ev[2] = 1'b1; ed[2] = 8'h5A; rd[2] = 1'b1;
    #1;
    checkOutput("bypass deq_valid", int'(dv[2]), 1);
    checkOutput("bypass deq_data", int'(dd[2]), 8'h5A);
    applyStimulus(2, 1'b1, 8'h5A, 1'b1, 1'b0);
    setIdle(2);
    checkOutput("bypass pass count", dutCount(2), 0);
    applyStimulus(2, 1'b1, 8'h5A, 1'b0, 1'b0);
    setIdle(2);
    checkOutput("bypass store count", dutCount(2), 1);
    checkOutput("bypass store data", int'(dd[2]), 8'h5A);
    applyStimulus(2, 1'b0, 8'h00, 1'b1, 1'b0);
    setIdle(2);

    $display("[TB] pipe mode full exchange");
    for (int k = 0; k < 4; k++) applyStimulus(3, 1'b1, fill[k], 1'b0, 1'b0);
    setIdle(3);
    checkOutput("pipe full count", dutCount(3), 4);
    checkOutput("pipe full no-deq ready", int'(er[3]), 0);
    ev[3] = 1'b1; ed[3] = 8'h55; rd[3] = 1'b1;
    #1;
    checkOutput("pipe full deq ready", int'(er[3]), 1);
    checkOutput("pipe head", int'(dd[3]), 8'h11);
    applyStimulus(3, 1'b1, 8'h55, 1'b1, 1'b0);
    setIdle(3);
    checkOutput("pipe exchange count", dutCount(3), 4);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("pipe drain %0d", k), int'(dd[3]), int'(pipeExp[k]));
      applyStimulus(3, 1'b0, 8'h00, 1'b1, 1'b0);
    end
    setIdle(3);

    $display("[TB] asynchronous reset mid-operation");
    applyStimulus(0, 1'b1, 8'h88, 1'b0, 1'b0);
    setIdle(0);
    checkOutput("pre-reset count", dutCount(0), 2);
    #2 reset = 1'b0;
    #1;
    checkOutput("async reset count", dutCount(0), 0);
    checkOutput("async reset deq_valid", int'(dv[0]), 0);
    checkOutput("async reset enq_ready", int'(er[0]), 1);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
